// File: rtl/status_banner_pkg.sv
// Shared types and tables for the status banner: character codes, segment
// patterns, stored messages and the run-status states.
`timescale 1ns/1ps
package status_banner_pkg;

  typedef enum logic [3:0] {
    CH_BLANK = 4'd0,
    CH_B     = 4'd1,
    CH_U     = 4'd2,
    CH_S     = 4'd3,
    CH_Y     = 4'd4,
    CH_P     = 4'd5,
    CH_A     = 4'd6,
    CH_E     = 4'd7,
    CH_R     = 4'd8,
    CH_O     = 4'd9
  } char_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MSG_BUSY = 2'd0,
    MSG_PASS = 2'd1,
    MSG_FAIL = 2'd2
  } msg_t;

  localparam int MSG_MAX_LEN = 5;
  localparam int LEN_BUSY    = 4;
  localparam int LEN_PASS    = 4;
  localparam int LEN_FAIL    = 5;

  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg_of(input char_t c);
    case (c)
      CH_B:    seg_of = 7'b1100000;
      CH_U:    seg_of = 7'b1000001;
      CH_S:    seg_of = 7'b0100100;
      CH_Y:    seg_of = 7'b1000100;
      CH_P:    seg_of = 7'b0011000;
      CH_A:    seg_of = 7'b0001000;
      CH_E:    seg_of = 7'b0110000;
      CH_R:    seg_of = 7'b1111010;
      CH_O:    seg_of = 7'b1100010;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic int msg_len(input msg_t m);
    case (m)
      MSG_BUSY: msg_len = LEN_BUSY;
      MSG_PASS: msg_len = LEN_PASS;
      default:  msg_len = LEN_FAIL;
    endcase
  endfunction

  // Character idx of a message, counted from its first (leftmost) character.
  function automatic char_t msg_char(input msg_t m, input int idx);
    msg_char = CH_BLANK;
    case (m)
      MSG_BUSY:
        case (idx)
          0:       msg_char = CH_B;
          1:       msg_char = CH_U;
          2:       msg_char = CH_S;
          3:       msg_char = CH_Y;
          default: msg_char = CH_BLANK;
        endcase
      MSG_PASS:
        case (idx)
          0:       msg_char = CH_P;
          1:       msg_char = CH_A;
          2:       msg_char = CH_S;
          3:       msg_char = CH_S;
          default: msg_char = CH_BLANK;
        endcase
      default:
        case (idx)
          0:       msg_char = CH_E;
          1:       msg_char = CH_R;
          2:       msg_char = CH_R;
          3:       msg_char = CH_O;
          4:       msg_char = CH_R;
          default: msg_char = CH_BLANK;
        endcase
    endcase
  endfunction

endpackage

// File: rtl/status_banner_seg_char_encoder.sv
// Combinational character-code to active-low 7-segment pattern, one per digit.
`timescale 1ns/1ps
module seg_char_encoder
  import status_banner_pkg::*;
(
  input  char_t       i_char,
  output logic [6:0]  o_seg
);

  assign o_seg = seg_of(i_char);

endmodule

// File: rtl/status_banner.sv
// Run-status banner: idle/busy/pass/fail FSM with latched result, rendered as
// static, blinking or right-to-left scrolling text on active-low 7-seg digits.
`timescale 1ns/1ps
module status_banner
  import status_banner_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    busy,
  input  logic                    done,
  input  logic                    incorrect,
  input  logic                    clear,
  input  logic [1:0]              mode,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    msg_active
);

  localparam int PER_MAX = NUM_DIGITS + MSG_MAX_LEN;
  localparam int POS_W   = $clog2(PER_MAX + 1);
  localparam int PRE_W   = $clog2(STEP_CYCLES);

  state_t                  r_state;
  logic                    r_done_d;
  logic                    r_incorrect;
  logic [1:0]              r_mode;
  logic [POS_W-1:0]        r_pos;
  logic                    r_phase;
  logic [PRE_W-1:0]        r_presc;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                    r_msg_active;

  state_t                  w_next;
  logic                    w_latch;
  logic                    w_done_rise;
  logic                    w_restart;
  logic                    w_running;
  logic                    w_tick;
  msg_t                    w_msg;
  int                      w_len;
  int                      w_period;
  int                      w_shown;
  char_t                   w_char [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_seg;

  assign w_done_rise = done & ~r_done_d;

  // clear beats a done edge, which beats busy
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    if (clear) begin
      w_next = ST_IDLE;
    end else if (w_done_rise) begin
      w_next  = ST_RESULT;
      w_latch = 1'b1;
    end else if (busy && (r_state != ST_BUSY)) begin
      w_next = ST_BUSY;
    end
  end

  assign w_restart = (w_next != r_state) || (mode != r_mode);
  assign w_running = (r_state == ST_BUSY) || (r_state == ST_RESULT);
  assign w_tick    = w_running && (r_presc == PRE_W'(STEP_CYCLES - 1));

  assign w_msg    = (r_state == ST_BUSY) ? MSG_BUSY :
                    (r_incorrect ? MSG_FAIL : MSG_PASS);
  assign w_len    = msg_len(w_msg);
  assign w_period = NUM_DIGITS + w_len;
  assign w_shown  = (w_len < NUM_DIGITS) ? w_len : NUM_DIGITS;

  // Character selection per digit; digit 0 is the rightmost.
  always_comb begin
    int s;
    s = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_char[d] = CH_BLANK;
      if (r_state != ST_IDLE) begin
        if (r_mode == MODE_SCROLL) begin
          s = int'(r_pos) + (NUM_DIGITS - 1 - d);
          if (s >= w_period) s = s - w_period;
          if (s >= NUM_DIGITS) w_char[d] = msg_char(w_msg, s - NUM_DIGITS);
        end else if ((r_mode != MODE_BLINK) || r_phase) begin
          if (d < w_shown) w_char[d] = msg_char(w_msg, w_shown - 1 - d);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg_char_encoder u_enc (
      .i_char (w_char[g]),
      .o_seg  (w_seg[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_done_d     <= 1'b0;
      r_incorrect  <= 1'b0;
      r_mode       <= 2'd0;
      r_pos        <= '0;
      r_phase      <= 1'b1;
      r_presc      <= '0;
      r_hex        <= '1;
      r_msg_active <= 1'b0;
    end else begin
      r_done_d <= done;
      r_state  <= w_next;
      r_mode   <= mode;
      if (w_latch) r_incorrect <= incorrect;

      if (w_restart) begin
        r_pos   <= '0;
        r_phase <= 1'b1;
        r_presc <= '0;
      end else begin
        if (w_running) r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
        if (w_tick) begin
          r_phase <= ~r_phase;
          // >= also covers a message swap to a shorter period mid-scroll
          r_pos   <= (int'(r_pos) >= w_period - 1) ? '0 : r_pos + POS_W'(1);
        end
      end

      r_hex        <= w_seg;
      r_msg_active <= (r_state != ST_IDLE);
    end
  end

  assign hex        = r_hex;
  assign msg_active = r_msg_active;

endmodule

// File: tb/tb_status_banner.sv
// Bench for status_banner (6 digits, 4-cycle steps): directed walk through the
// run states and display modes, then randomized inputs against a string model.
`timescale 1ns/1ps
module tb_status_banner;

  localparam int ND   = 6;
  localparam int STEP = 4;
  localparam int M_IDLE = 0, M_BUSY = 1, M_RESULT = 2;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SEG_B = 7'b1100000, SEG_U = 7'b1000001, SEG_S = 7'b0100100;
  localparam logic [6:0] SEG_Y = 7'b1000100, SEG_P = 7'b0011000, SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_E = 7'b0110000, SEG_R = 7'b1111010;
  localparam logic [7*ND-1:0] ALL_BLANK = {ND{SB}};

  logic clk = 1'b0;
  logic rst, busy, done, incorrect, clear;
  logic [1:0] mode;
  logic [7*ND-1:0] hex;
  logic msg_active;

  int n_pass = 0;
  int n_total = 0;
  int cyc_no = 0;

  // reference model state
  int   m_state;
  bit   m_res;
  logic [1:0] m_mode;
  int   m_cnt;
  bit   m_done_prev;
  logic [7*ND-1:0] exp_hex;
  logic exp_act;

  status_banner #(.NUM_DIGITS(ND), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .busy(busy), .done(done), .incorrect(incorrect),
    .clear(clear), .mode(mode), .hex(hex), .msg_active(msg_active)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of_ch(input byte ch);
    case (ch)
      "b": return SEG_B;
      "U": return SEG_U;
      "S": return SEG_S;
      "Y": return SEG_Y;
      "P": return SEG_P;
      "A": return SEG_A;
      "E": return SEG_E;
      "r": return SEG_R;
      "o": return 7'b1100010;
      default: return SB;
    endcase
  endfunction

  // Display computed from text: static line right-aligned, blink by step
  // parity, scroll over the string of ND blanks followed by the message.
  function automatic logic [7*ND-1:0] render(input int st, input bit res,
                                             input logic [1:0] md, input int cnt);
    string msg, line, virt;
    int len, n_step, per, p, idx;
    byte ch;
    logic [7*ND-1:0] out;
    out = ALL_BLANK;
    if (st == M_IDLE) return out;
    msg = (st == M_BUSY) ? "bUSY" : (res ? "Error" : "PASS");
    len = msg.len();
    n_step = cnt / STEP;
    line = "";
    for (int j = 0; j < ND - len; j++) line = {line, " "};
    line = (len <= ND) ? {line, msg} : msg.substr(0, ND - 1);
    virt = "";
    for (int j = 0; j < ND; j++) virt = {virt, " "};
    virt = {virt, msg};
    per = ND + len;
    p = n_step % per;
    for (int i = 0; i < ND; i++) begin
      if (md == 2'd2) begin
        idx = (p + (ND - 1 - i)) % per;
        ch = virt[idx];
      end else if (md == 2'd1 && (n_step % 2) == 1) begin
        ch = " ";
      end else begin
        ch = line[ND - 1 - i];
      end
      out[7*i +: 7] = seg_of_ch(ch);
    end
    return out;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_res = 0; m_mode = 2'd0; m_cnt = 0; m_done_prev = 0;
  endtask

  // Advance the model across one clock edge using the applied inputs.
  task automatic model_edge();
    int nxt;
    bit rise;
    if (rst) begin
      exp_hex = ALL_BLANK;
      exp_act = 1'b0;
      model_reset();
      return;
    end
    exp_hex = render(m_state, m_res, m_mode, m_cnt);
    exp_act = (m_state != M_IDLE);
    rise = done && !m_done_prev;
    m_done_prev = done;
    nxt = m_state;
    if (clear) nxt = M_IDLE;
    else if (rise) begin nxt = M_RESULT; m_res = incorrect; end
    else if (busy && m_state != M_BUSY) nxt = M_BUSY;
    if (nxt != m_state || mode != m_mode) m_cnt = 0;
    else if (m_state != M_IDLE) m_cnt++;
    m_state = nxt;
    m_mode = mode;
  endtask

  task automatic check(input string tag, input logic [7*ND-1:0] obs,
                       input logic [7*ND-1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_no, obs, expv);
  endtask

  task automatic cyc(input logic b, input logic d, input logic inc, input logic clr,
                     input logic r, input logic [1:0] md);
    busy = b; done = d; incorrect = inc; clear = clr; rst = r; mode = md;
    @(posedge clk);
    model_edge();
    #1;
    cyc_no++;
    check("model_hex", hex, exp_hex);
    check("model_act", {{(7*ND-1){1'b0}}, msg_active}, {{(7*ND-1){1'b0}}, exp_act});
  endtask

  initial begin
    logic b, d, inc, clr, r;
    logic [1:0] md;
    model_reset();
    busy = 0; done = 0; incorrect = 0; clear = 0; mode = 2'd0; rst = 1;
    #1;

    // reset, then idle
    cyc(0, 0, 0, 0, 1, 2'd0);
    cyc(0, 0, 0, 0, 1, 2'd0);
    check("reset_hex", hex, ALL_BLANK);
    check("reset_act", {41'b0, msg_active}, 42'd0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 2'd0);
    check("idle_hex", hex, ALL_BLANK);

    // busy, static
    cyc(1, 0, 0, 0, 0, 2'd0);
    cyc(1, 0, 0, 0, 0, 2'd0);
    check("busy_hex", hex, {SB, SB, SEG_B, SEG_U, SEG_S, SEG_Y});
    check("busy_act", {41'b0, msg_active}, 42'd1);

    // done with incorrect=1 -> Error, then hold with incorrect=0
    cyc(0, 1, 1, 0, 0, 2'd0);
    cyc(0, 0, 0, 0, 0, 2'd0);
    check("err_hex", hex, {SB, SEG_E, SEG_R, SEG_R, 7'b1100010, SEG_R});
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 2'd0);
    check("err_hold_d4", {35'b0, hex[28 +: 7]}, {35'b0, SEG_E});
    check("err_hold_d0", {35'b0, hex[0 +: 7]}, {35'b0, SEG_R});

    // PASS in blink mode: digit 0 on for 4 cycles, off for 4
    cyc(0, 1, 0, 0, 0, 2'd1);
    for (int k = 2; k <= 13; k++) begin
      cyc(0, 0, 0, 0, 0, 2'd1);
      check($sformatf("blink_d0_k%0d", k), {35'b0, hex[0 +: 7]},
            {35'b0, ((((k - 2) / 4) % 2) == 0) ? SEG_S : SB});
    end

    // PASS in scroll mode: position p visible from step 2+4p
    cyc(0, 0, 0, 0, 0, 2'd2);
    for (int k = 2; k <= 42; k++) begin
      cyc(0, 0, 0, 0, 0, 2'd2);
      if (k == 2)  check("scroll_p0", hex, ALL_BLANK);
      if (k == 6)  check("scroll_p1", hex, {SB, SB, SB, SB, SB, SEG_P});
      if (k == 18) check("scroll_p4", hex, {SB, SB, SEG_P, SEG_A, SEG_S, SEG_S});
      if (k == 38) check("scroll_p9_d5", {35'b0, hex[35 +: 7]}, {35'b0, SEG_S});
      if (k == 42) check("scroll_wrap", hex, ALL_BLANK);
    end
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 2'd2);
    cyc(0, 0, 0, 0, 1, 2'd2);
    check("rst_mid_hex", hex, ALL_BLANK);
    check("rst_mid_act", {41'b0, msg_active}, 42'd0);
    cyc(0, 0, 0, 0, 0, 2'd0);

    // done edge together with clear -> IDLE, no result
    cyc(1, 0, 0, 0, 0, 2'd0);
    cyc(1, 0, 0, 0, 0, 2'd0);
    cyc(0, 1, 1, 1, 0, 2'd0);
    cyc(0, 0, 0, 0, 0, 2'd0);
    check("clr_win_hex", hex, ALL_BLANK);
    cyc(0, 0, 0, 0, 0, 2'd0);
    check("clr_win_act", {41'b0, msg_active}, 42'd0);

    // done held high: one edge only
    cyc(0, 1, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 0, 0, 2'd0);
    check("pass_hex", hex, {SB, SB, SEG_P, SEG_A, SEG_S, SEG_S});
    cyc(0, 1, 1, 1, 0, 2'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 2'd0);
    check("held_hex", hex, ALL_BLANK);
    check("held_act", {41'b0, msg_active}, 42'd0);

    // randomized traffic against the model
    d = 0; md = 2'd0;
    for (int i = 0; i < 800; i++) begin
      b   = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 9) == 0) d = ~d;
      clr = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 3) md = 2'($urandom_range(0, 3));
      inc = (m_state == M_RESULT) ? m_res : 1'($urandom_range(0, 1));
      cyc(b, d, inc, clr, r, md);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
